// File: rtl/spi_uart_streamer.sv
// spi_uart_streamer: starts an SPI ADC conversion, latches NCH samples and streams them
// as a framed byte sequence to a UART. Define CHECKSUM_EN to append an XOR checksum byte.
module spi_uart_streamer #(
  parameter int         NCH     = 2,
  parameter int         DW      = 12,
  parameter int         PERIOD  = 1000000,
  parameter int         TIMEOUT = 4096,
  parameter logic [7:0] HDR     = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic              cont_en,
  input  logic [NCH*DW-1:0] data,
  input  logic              done,
  output logic              start,
  output logic [7:0]        TxD_data,
  output logic              TxD_start,
  input  logic              TxD_busy,
  output logic              busy,
  output logic              overrun,
  output logic              timeout_err
);

  localparam int BPC = (DW + 7) / 8;
  localparam int EW  = 8 * BPC;
  localparam int NDB = NCH * BPC;
`ifdef CHECKSUM_EN
  localparam int L   = NDB + 2;
`else
  localparam int L   = NDB + 1;
`endif
  localparam int IW  = $clog2(L + 1);
  localparam int CW  = $clog2(TIMEOUT + 1);
  localparam int PW  = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CONV, S_SEND, S_GUARD, S_WAIT} state_t;

  state_t            state_reg, state_next;
  logic              start_reg, start_next;
  logic              timeout_reg, timeout_next;
  logic              overrun_reg, overrun_next;
  logic [7:0]        tx_data_reg, tx_data_next;
  logic [IW-1:0]     idx_reg, idx_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [NCH*DW-1:0] shadow_reg, shadow_next;
  logic [PW-1:0]     pcnt_reg, pcnt_next;
`ifdef CHECKSUM_EN
  logic [7:0]        csum_reg, csum_next;
`endif

  logic              tick;
  logic              req;
  logic              tx_start;
  logic [IW-1:0]     idx_plus;
  logic [7:0]        next_byte;
  logic [EW-1:0]     ch_ext [NCH];
  logic [7:0]        frame_byte [1:L-1];

  // Byte 0 is always HDR and is loaded directly; only bytes 1..L-1 are muxed.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      assign ch_ext[gi] = EW'(shadow_reg[gi*DW +: DW]);
    end
    for (gi = 0; gi < NDB; gi++) begin : g_byte
      assign frame_byte[gi+1] = ch_ext[gi/BPC][8*(BPC-1-(gi%BPC)) +: 8];
    end
  endgenerate

`ifdef CHECKSUM_EN
  assign frame_byte[L-1] = csum_reg;
`endif

  assign tick     = cont_en && (pcnt_reg == PW'(PERIOD - 1));
  assign req      = trig || tick;
  assign idx_plus = idx_reg + IW'(1);

  always_comb begin
    next_byte = 8'h00;
    for (int k = 1; k < L; k++) begin
      if (idx_plus == IW'(k)) next_byte = frame_byte[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      start_reg   <= 1'b0;
      timeout_reg <= 1'b0;
      overrun_reg <= 1'b0;
      tx_data_reg <= 8'h00;
      idx_reg     <= '0;
      cnt_reg     <= '0;
      shadow_reg  <= '0;
      pcnt_reg    <= '0;
`ifdef CHECKSUM_EN
      csum_reg    <= 8'h00;
`endif
    end else begin
      state_reg   <= state_next;
      start_reg   <= start_next;
      timeout_reg <= timeout_next;
      overrun_reg <= overrun_next;
      tx_data_reg <= tx_data_next;
      idx_reg     <= idx_next;
      cnt_reg     <= cnt_next;
      shadow_reg  <= shadow_next;
      pcnt_reg    <= pcnt_next;
`ifdef CHECKSUM_EN
      csum_reg    <= csum_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    start_next   = 1'b0;
    timeout_next = 1'b0;
    overrun_next = overrun_reg;
    tx_data_next = tx_data_reg;
    idx_next     = idx_reg;
    cnt_next     = cnt_reg;
    shadow_next  = shadow_reg;
    tx_start     = 1'b0;
`ifdef CHECKSUM_EN
    csum_next    = csum_reg;
`endif

    if (!cont_en || tick) pcnt_next = '0;
    else                  pcnt_next = pcnt_reg + PW'(1);

    // A request arriving outside IDLE is dropped and only flagged.
    if (req) overrun_next = (state_reg != S_IDLE);

    case (state_reg)
      S_IDLE: begin
        if (req) begin
          state_next = S_CONV;
          start_next = 1'b1;
          cnt_next   = CW'(TIMEOUT);
        end
      end
      S_CONV: begin
        if (done) begin
          shadow_next  = data;
          idx_next     = '0;
          tx_data_next = HDR;
          state_next   = S_SEND;
`ifdef CHECKSUM_EN
          csum_next    = 8'h00;
`endif
        end else if (cnt_reg <= CW'(1)) begin
          timeout_next = 1'b1;
          state_next   = S_IDLE;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      S_SEND: begin
        if (!TxD_busy) begin
          tx_start   = 1'b1;
          state_next = S_GUARD;
`ifdef CHECKSUM_EN
          csum_next  = csum_reg ^ tx_data_reg;
`endif
        end
      end
      S_GUARD: state_next = S_WAIT;
      S_WAIT: begin
        if (!TxD_busy) begin
          if (idx_reg == IW'(L - 1)) begin
            state_next = S_IDLE;
          end else begin
            idx_next     = idx_plus;
            tx_data_next = next_byte;
            state_next   = S_SEND;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign start       = start_reg;
  assign TxD_data    = tx_data_reg;
  assign TxD_start   = tx_start;
  assign busy        = (state_reg != S_IDLE);
  assign overrun     = overrun_reg;
  assign timeout_err = timeout_reg;

endmodule

// File: tb/tb_spi_uart_streamer.sv
// Directed bench for spi_uart_streamer (NCH=2, DW=12, PERIOD=200, TIMEOUT=16).
// Honours CHECKSUM_EN so the expected frame matches the build under test.
module tb_spi_uart_streamer;

`ifdef CHECKSUM_EN
  localparam int FL = 6;
`else
  localparam int FL = 5;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trig = 1'b0;
  logic        cont_en = 1'b0;
  logic [23:0] data = 24'h0;
  logic        done;
  logic        done_dir = 1'b0;
  logic        done_auto = 1'b0;
  logic        auto_en = 1'b0;
  logic        start;
  logic [7:0]  TxD_data;
  logic        TxD_start;
  logic        TxD_busy;
  logic        busy;
  logic        overrun;
  logic        timeout_err;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ubusy = 0;
  int          dcnt = 0;
  int          tx_starts = 0;
  logic [7:0]  rx_q [$];
  int          start_cyc [$];

  assign done     = done_dir | done_auto;
  assign TxD_busy = (ubusy != 0);

  spi_uart_streamer #(
    .NCH(2), .DW(12), .PERIOD(200), .TIMEOUT(16), .HDR(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .trig(trig), .cont_en(cont_en), .data(data),
    .done(done), .start(start), .TxD_data(TxD_data), .TxD_start(TxD_start),
    .TxD_busy(TxD_busy), .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // UART model: busy rises the cycle after TxD_start and lasts 10 cycles.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (TxD_start) ubusy <= 10;
    else if (ubusy != 0) ubusy <= ubusy - 1;
  end

  always @(negedge clk) begin
    if (TxD_start) begin
      rx_q.push_back(TxD_data);
      tx_starts++;
    end
    if (start) start_cyc.push_back(cyc);
  end

  // ADC model for continuous mode: done 4 cycles after each start.
  always @(negedge clk) begin
    done_auto = (dcnt == 1);
    if (dcnt > 0) dcnt = dcnt - 1;
    if (auto_en && start) dcnt = 4;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic pulse_done();
    done_dir = 1'b1;
    @(negedge clk);
    done_dir = 1'b0;
  endtask

  task automatic wait_frame(input string tag, input int budget);
    int n = 0;
    while ((busy === 1'b1 || TxD_busy === 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_bound"}, 32'(n < budget), 32'd1);
  endtask

  task automatic check_frame(input string tag, input int base,
                             input logic [11:0] c0, input logic [11:0] c1);
    logic [7:0] e [6];
    logic [7:0] ob;
    e[0] = 8'hA5;
    e[1] = {4'h0, c0[11:8]};
    e[2] = c0[7:0];
    e[3] = {4'h0, c1[11:8]};
    e[4] = c1[7:0];
    e[5] = e[0] ^ e[1] ^ e[2] ^ e[3] ^ e[4];
    for (int i = 0; i < FL; i++) begin
      ob = 8'hxx;
      if (base + i < rx_q.size()) ob = rx_q[base + i];
      chk($sformatf("%s_byte%0d", tag, i), 32'(ob), 32'(e[i]));
    end
  endtask

  initial begin
    int n;
    int ts0;
    int ns0;

    // reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_txstart", 32'(TxD_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_txdata", 32'(TxD_data), 32'd0);

    // done outside CONV is ignored
    pulse_done();
    chk("idle_done_busy", 32'(busy), 32'd0);
    chk("idle_done_txstart", 32'(TxD_start), 32'd0);

    // 1. single shot; data changes after the latch must not leak into the frame
    data = {12'h123, 12'hABC};
    rx_q.delete();
    pulse_trig();
    chk("t1_start_latency", 32'(start), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    repeat (4) @(negedge clk);
    pulse_done();
    chk("t1_txstart_latency", 32'(TxD_start), 32'd1);
    chk("t1_first_byte", 32'(TxD_data), 32'hA5);
    data = 24'hFFFFFF;
    wait_frame("t1", 300);
    chk("t1_len", 32'(rx_q.size()), 32'(FL));
    check_frame("t1", 0, 12'hABC, 12'h123);
    chk("t1_busy_end", 32'(busy), 32'd0);

    // 3. timeout after 16 cycles without done
    ts0 = tx_starts;
    pulse_trig();
    chk("t3_start", 32'(start), 32'd1);
    repeat (15) @(negedge clk);
    chk("t3_no_early_timeout", 32'(timeout_err), 32'd0);
    @(negedge clk);
    chk("t3_timeout_pulse", 32'(timeout_err), 32'd1);
    chk("t3_idle", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t3_timeout_one_cycle", 32'(timeout_err), 32'd0);
    chk("t3_no_bytes", 32'(tx_starts), 32'(ts0));

    // 4. overrun: second trig while the first frame is in flight
    data = {12'h0F0, 12'h00F};
    rx_q.delete();
    ns0 = start_cyc.size();
    pulse_trig();
    repeat (4) @(negedge clk);
    pulse_done();
    repeat (3) @(negedge clk);
    pulse_trig();
    chk("t4_overrun_set", 32'(overrun), 32'd1);
    wait_frame("t4", 300);
    chk("t4_len", 32'(rx_q.size()), 32'(FL));
    check_frame("t4", 0, 12'h00F, 12'h0F0);
    chk("t4_one_start", 32'(start_cyc.size()), 32'(ns0 + 1));
    chk("t4_overrun_sticky", 32'(overrun), 32'd1);
    pulse_trig();
    chk("t4_overrun_clear", 32'(overrun), 32'd0);
    chk("t4_restart", 32'(start), 32'd1);
    repeat (4) @(negedge clk);
    pulse_done();
    wait_frame("t4b", 300);

    // 5. continuous mode at PERIOD=200
    data = {12'h123, 12'hABC};
    rx_q.delete();
    start_cyc.delete();
    auto_en = 1'b1;
    cont_en = 1'b1;
    repeat (650) @(negedge clk);
    cont_en = 1'b0;
    wait_frame("t5", 300);
    repeat (300) @(negedge clk);
    auto_en = 1'b0;
    chk("t5_starts", 32'(start_cyc.size()), 32'd3);
    if (start_cyc.size() >= 3) begin
      chk("t5_period_a", 32'(start_cyc[1] - start_cyc[0]), 32'd200);
      chk("t5_period_b", 32'(start_cyc[2] - start_cyc[1]), 32'd200);
    end
    chk("t5_bytes", 32'(rx_q.size()), 32'(3 * FL));
    check_frame("t5f0", 0, 12'hABC, 12'h123);
    check_frame("t5f2", 2 * FL, 12'hABC, 12'h123);
    chk("t5_no_overrun", 32'(overrun), 32'd0);

    // 6. reset during byte 3, then a fresh frame
    rx_q.delete();
    pulse_trig();
    repeat (4) @(negedge clk);
    pulse_done();
    n = 0;
    while (rx_q.size() < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach_byte3", 32'(n < 100), 32'd1);
    pulse_trig();
    chk("t6_overrun_before", 32'(overrun), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_txstart", 32'(TxD_start), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_overrun", 32'(overrun), 32'd0);
    ts0 = tx_starts;
    repeat (5) @(negedge clk);
    chk("t6_frame_dropped", 32'(tx_starts), 32'(ts0));
    data = {12'h456, 12'h789};
    rx_q.delete();
    pulse_trig();
    repeat (4) @(negedge clk);
    pulse_done();
    wait_frame("t6", 300);
    chk("t6_len", 32'(rx_q.size()), 32'(FL));
    check_frame("t6", 0, 12'h789, 12'h456);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
